eth_stats_arbiter: RTL

- Shares one 64-bit AXI4-Stream output, feeding the PS-side FIFO/DMA path, between C_NUM_PORTS Ethernet statistics collectors.
- Each collector raises a request when it holds a new snapshot. The arbiter grants requesters round-robin, captures the granted snapshot in one cycle and serializes it as an 8-word packet.
- Sits in the clk domain, downstream of the per-port collectors' CDC.

---
 rtl/eth_stats_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/eth_stats_arbiter.sv
// Round-robin arbiter that captures one collector snapshot and streams it as an 8-word AXIS packet.
// Optional ESA_SKIP_UNCHANGED_EN: acknowledge but drop snapshots whose stats_id repeats the last one sent.
module eth_stats_arbiter #(
  parameter int C_NUM_PORTS = 4,
  parameter int C_ID_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [C_NUM_PORTS-1:0]     req,
  output logic [C_NUM_PORTS-1:0]     ack,
  input  logic [6*C_NUM_PORTS-1:0]   stats_id,
  input  logic [448*C_NUM_PORTS-1:0] rec_data,
  output logic [63:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]      m_axis_tdest,
  output logic                       busy
`ifdef ESA_SKIP_UNCHANGED_EN
  ,
  output logic [31:0]                skipped_count
`endif
);

  localparam int IDX_W = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       last_grant_reg;
  logic [IDX_W-1:0]       grant_idx_reg;
  logic [2:0]             word_cnt_reg;
  logic [447:0]           rec_reg;
  logic [5:0]             id_reg;
  logic [C_NUM_PORTS-1:0] ack_reg;
  logic [63:0]            tdata_reg;
  logic                   tvalid_reg;
  logic                   tlast_reg;
  logic [C_ID_WIDTH-1:0]  tdest_reg;
  logic                   busy_reg;

  logic [447:0]           rec_arr [C_NUM_PORTS];
  logic [5:0]             id_arr [C_NUM_PORTS];
  logic [63:0]            rec_word [8];
  logic [7:0]             hdr_idx;
  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic                   skip_hit;

  generate
    for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_port
      assign rec_arr[gi] = rec_data[448*gi +: 448];
      assign id_arr[gi]  = stats_id[6*gi +: 6];
    end
  endgenerate

  // Word 0 is the header; words 1..7 walk the snapshot from time (MSBs) down to rx_bad.
  assign hdr_idx     = 8'(grant_idx_reg);
  assign rec_word[0] = {hdr_idx, 50'b0, id_reg};
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_word
      assign rec_word[gi] = rec_reg[64*(7-gi) +: 64];
    end
  endgenerate

  // Scan from last_grant+1 with wrap; iterating downward lets the nearest requester win.
  always_comb begin
    int p;
    p         = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = C_NUM_PORTS; k >= 1; k--) begin
      p = int'(last_grant_reg) + k;
      if (p >= C_NUM_PORTS) p = p - C_NUM_PORTS;
      if (req[IDX_W'(p)]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(p);
      end
    end
  end

`ifdef ESA_SKIP_UNCHANGED_EN
  logic [5:0]             last_id_reg [C_NUM_PORTS];
  logic [C_NUM_PORTS-1:0] id_valid_reg;
  logic [31:0]            skipped_reg;

  assign skip_hit      = id_valid_reg[grant_idx_reg] &&
                         (id_arr[grant_idx_reg] == last_id_reg[grant_idx_reg]);
  assign skipped_count = skipped_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_PORTS; i++) last_id_reg[i] <= '0;
      id_valid_reg <= '0;
      skipped_reg  <= '0;
    end else if (state_reg == S_CAPTURE) begin
      if (skip_hit) begin
        if (skipped_reg != 32'hFFFF_FFFF) skipped_reg <= skipped_reg + 32'd1;
      end else begin
        last_id_reg[grant_idx_reg]  <= id_arr[grant_idx_reg];
        id_valid_reg[grant_idx_reg] <= 1'b1;
      end
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= IDX_W'(C_NUM_PORTS - 1);
      grant_idx_reg  <= '0;
      word_cnt_reg   <= '0;
      rec_reg        <= '0;
      id_reg         <= '0;
      ack_reg        <= '0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tdest_reg      <= '0;
      busy_reg       <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (enable && sel_valid) begin
            grant_idx_reg <= sel_idx;
            busy_reg      <= 1'b1;
            state_reg     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          ack_reg[grant_idx_reg] <= 1'b1;
          last_grant_reg         <= grant_idx_reg;
          word_cnt_reg           <= '0;
          rec_reg                <= rec_arr[grant_idx_reg];
          id_reg                 <= id_arr[grant_idx_reg];
          tdest_reg              <= C_ID_WIDTH'(grant_idx_reg);
          if (skip_hit) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_SEND;
          end
        end
        S_SEND: begin
          // First SEND cycle (the ack cycle) presents the header; then advance per handshake.
          if (!tvalid_reg) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= rec_word[0];
            tlast_reg  <= 1'b0;
          end else if (m_axis_tready) begin
            if (word_cnt_reg == 3'd7) begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              busy_reg   <= 1'b0;
              state_reg  <= S_IDLE;
            end else begin
              word_cnt_reg <= word_cnt_reg + 3'd1;
              tdata_reg    <= rec_word[word_cnt_reg + 3'd1];
              tlast_reg    <= (word_cnt_reg == 3'd6);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ack           = ack_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tdest  = tdest_reg;
  assign busy          = busy_reg;

endmodule
